bus_rr_fabric: RTL

- Parametrised single-layer shared bus for the SoC: N masters, M slaves.
- Contains:
  - a registered round-robin arbiter;
  - a master-side mux;
  - a high-order address decoder;
  - a slave-side return mux;
  - a ready-timeout watchdog that terminates hung transfers with an error strobe.
- Sits between the CPU/DMA masters and the memory/peripheral slaves. All control strobes are active-low.

---
 rtl/bus_rr_fabric_pkg.sv | 21 ++
 rtl/bus_rr_arbiter.sv | 96 +++++++++
 rtl/bus_rr_fabric.sv | 120 ++++++++++++
 3 files changed

// File: rtl/bus_rr_fabric_pkg.sv
// Shared definitions for the round-robin bus fabric: strobe levels,
// direction encoding, default widths, watchdog width, arbiter states.
package bus_rr_fabric_pkg;

  // active-low strobe levels
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  // out_rw / m_rw encoding
  localparam logic READ  = 1'b1;
  localparam logic WRITE = 1'b0;

  localparam int DEF_ADDR_W = 30;
  localparam int DEF_DATA_W = 32;

  // watchdog counter width; TIMEOUT_CYCLES tops out at 65535
  localparam int WDOG_W = 16;

  typedef enum logic {ARB_IDLE, ARB_OWNED} arb_state_t;

endpackage

// File: rtl/bus_rr_arbiter.sv
// Registered, non-preemptive round-robin arbiter with a one-cold grant.
// The pointer always holds the current/last owner, so the search for the
// next winner starts one past it.
module bus_rr_arbiter
  import bus_rr_fabric_pkg::*;
#(
  parameter int NUM_MASTERS = 4
) (
  input  logic                           clk,
  input  logic                           reset_,
  input  logic [NUM_MASTERS-1:0]         req_,
  output logic [NUM_MASTERS-1:0]         grnt_,
  output logic [$clog2(NUM_MASTERS)-1:0] owner,
  output logic                           owner_vld
);

  localparam int MW = $clog2(NUM_MASTERS);

  arb_state_t             state, state_n;
  logic [MW-1:0]          ptr, ptr_n;
  logic [NUM_MASTERS-1:0] grnt_n;
  logic [NUM_MASTERS-1:0] req;
  logic [MW-1:0]          pick;
  logic                   pick_vld;

  assign req = ~req_;

  // first requester after ptr with wraparound; scanning far-to-near lets
  // the nearest one overwrite the rest
  always_comb begin
    int            sum;
    logic [MW-1:0] idx;
    sum      = 0;
    idx      = '0;
    pick     = '0;
    pick_vld = 1'b0;
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      sum = int'(ptr) + k;
      idx = MW'(sum % NUM_MASTERS);
      if (req[idx]) begin
        pick     = idx;
        pick_vld = 1'b1;
      end
    end
  end

  // next state: take the bus from IDLE, hold while the owner requests,
  // hand over directly on release or fall back to IDLE
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    grnt_n  = grnt_;
    case (state)
      ARB_IDLE: begin
        if (pick_vld) begin
          state_n = ARB_OWNED;
          ptr_n   = pick;
          grnt_n  = ~(NUM_MASTERS'(1) << pick);
        end
      end
      ARB_OWNED: begin
        if (!req[ptr]) begin
          if (pick_vld) begin
            ptr_n  = pick;
            grnt_n = ~(NUM_MASTERS'(1) << pick);
          end else begin
            state_n = ARB_IDLE;
            grnt_n  = '1;
          end
        end
      end
      default: begin
        state_n = ARB_IDLE;
        grnt_n  = '1;
      end
    endcase
  end

  // state, pointer and grant registers; reset points at the last master
  // so master 0 wins first
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state <= ARB_IDLE;
      ptr   <= MW'(NUM_MASTERS - 1);
      grnt_ <= '1;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      grnt_ <= grnt_n;
    end
  end

  assign owner     = ptr;
  assign owner_vld = (state == ARB_OWNED);

endmodule

// File: rtl/bus_rr_fabric.sv
// Single-layer shared bus: round-robin arbiter, master mux, high-order
// address decoder, slave return mux and optional ready-timeout watchdog.
// Define BUS_TIMEOUT_EN to build the watchdog; without it out_err_ is
// tied inactive and a hung slave stalls the bus.
module bus_rr_fabric
  import bus_rr_fabric_pkg::*;
#(
  parameter int NUM_MASTERS    = 4,
  parameter int NUM_SLAVES     = 8,
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                          clk,
  input  logic                          reset_,
  input  logic [NUM_MASTERS-1:0]        m_req_,
  input  logic [NUM_MASTERS-1:0]        m_as_,
  input  logic [NUM_MASTERS-1:0]        m_rw,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_wr_data,
  output logic [NUM_MASTERS-1:0]        m_grnt_,
  input  logic [NUM_SLAVES-1:0]         s_ready_,
  input  logic [NUM_SLAVES*DATA_W-1:0]  s_rd_data,
  output logic [NUM_SLAVES-1:0]         s_cs_,
  output logic [ADDR_W-1:0]             out_addr,
  output logic                          out_as_,
  output logic                          out_rw,
  output logic [DATA_W-1:0]             out_wr_data,
  output logic                          out_ready_,
  output logic [DATA_W-1:0]             out_rd_data,
  output logic                          out_err_
);

  localparam int MW = $clog2(NUM_MASTERS);
  localparam int SW = $clog2(NUM_SLAVES);

  if (NUM_SLAVES != (1 << SW)) begin : g_bad_slaves
    $error("NUM_SLAVES must be a power of two");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES out of range");
  end

  logic [MW-1:0]     owner;
  logic              owner_vld;
  logic [SW-1:0]     sel;
  logic              slv_rdy_;
  logic [DATA_W-1:0] slv_data;

  bus_rr_arbiter #(.NUM_MASTERS(NUM_MASTERS)) u_arb (
    .clk       (clk),
    .reset_    (reset_),
    .req_      (m_req_),
    .grnt_     (m_grnt_),
    .owner     (owner),
    .owner_vld (owner_vld)
  );

  // master-side mux driven by the registered grant; idle bus when ungranted
  always_comb begin
    out_as_     = DISABLE_;
    out_rw      = READ;
    out_addr    = '0;
    out_wr_data = '0;
    if (owner_vld) begin
      out_as_     = m_as_[owner];
      out_rw      = m_rw[owner];
      out_addr    = m_addr[owner*ADDR_W +: ADDR_W];
      out_wr_data = m_wr_data[owner*DATA_W +: DATA_W];
    end
  end

  assign sel = out_addr[ADDR_W-1 -: SW];

  // decoder and return mux; chip select follows the grant, slaves
  // qualify with out_as_ themselves
  always_comb begin
    s_cs_    = '1;
    slv_rdy_ = DISABLE_;
    slv_data = '0;
    if (owner_vld) begin
      s_cs_[sel] = ENABLE_;
      slv_rdy_   = s_ready_[sel];
      slv_data   = s_rd_data[sel*DATA_W +: DATA_W];
    end
  end

`ifdef BUS_TIMEOUT_EN
  logic [WDOG_W-1:0]      wd_cnt, wd_eff;
  logic [NUM_MASTERS-1:0] grnt_q;
  logic                   wd_fire;

  // a grant that changed on the last edge starts a fresh count
  assign wd_eff  = (m_grnt_ != grnt_q) ? '0 : wd_cnt;
  // a real ready in the same cycle wins over the timeout
  assign wd_fire = (out_as_ == ENABLE_) && (slv_rdy_ == DISABLE_) &&
                   (wd_eff == WDOG_W'(TIMEOUT_CYCLES - 1));

  assign out_ready_  = slv_rdy_ & ~wd_fire;
  assign out_err_    = ~wd_fire;
  assign out_rd_data = wd_fire ? '0 : slv_data;

  // count stalled strobe cycles; any ready (real or forced) or idle strobe clears
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      wd_cnt <= '0;
      grnt_q <= '1;
    end else begin
      grnt_q <= m_grnt_;
      if (out_as_ == DISABLE_ || out_ready_ == ENABLE_) wd_cnt <= '0;
      else                                              wd_cnt <= wd_eff + 1'b1;
    end
  end
`else
  assign out_ready_  = slv_rdy_;
  assign out_err_    = DISABLE_;
  assign out_rd_data = slv_data;
`endif

endmodule
